// File: rtl/mbist_march_ctrl.sv
// -----------------------------------------------------------------------------
// mbist_march_ctrl
//
// Runs a March C- test over one synchronous-write / registered-read memory:
//   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
// Write-only addresses take one cycle (WR). Read addresses take two cycles:
// RD issues the read, then CMP checks the returned data and, in E1-E4, writes.
// Total runtime is 11 * 2**AWIDTH cycles when no miscompare is seen.
//
// Optional feature: define MBIST_DIAG_EN to add o_err_cnt. The test then never
// aborts: every miscompare is counted (saturating) and o_fail_* keep the first.
// Without it, the first miscompare suppresses that CMP cycle's write and ends
// the test.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   i_start              one-cycle pulse, accepted in IDLE or DONE
//   o_busy, o_done       test running / test finished (held until next start)
//   o_fail               miscompare seen, valid with o_done
//   o_fail_elem/addr/data  element, address and read data of first miscompare
//   o_err_cnt            miscompare count (MBIST_DIAG_EN only)
//   o_mem_we/wraddr/datain  memory write port
//   o_mem_re/rdaddr      memory read port
//   i_mem_dataout        memory read data, valid the cycle after o_mem_re
// -----------------------------------------------------------------------------
module mbist_march_ctrl #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic [2:0]        o_fail_elem,
  output logic [AWIDTH-1:0] o_fail_addr,
  output logic [DWIDTH-1:0] o_fail_data,
`ifdef MBIST_DIAG_EN
  output logic [15:0]       o_err_cnt,
`endif
  output logic              o_mem_we,
  output logic [AWIDTH-1:0] o_mem_wraddr,
  output logic [DWIDTH-1:0] o_mem_datain,
  output logic              o_mem_re,
  output logic [AWIDTH-1:0] o_mem_rdaddr,
  input  logic [DWIDTH-1:0] i_mem_dataout
);

  localparam logic [AWIDTH-1:0] LastAddr = {AWIDTH{1'b1}};

  typedef enum logic [2:0] {StIdle, StWr, StRd, StCmp, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [2:0]          r_elem, w_elem_d;
  logic [AWIDTH-1:0]   r_addr, w_addr_d;

  logic                w_down;
  logic                w_last;
  logic [AWIDTH-1:0]   w_addr_step;
  logic [AWIDTH-1:0]   w_addr_first_next;
  logic [DWIDTH-1:0]   w_exp;
  logic                w_miscmp;
  logic                w_abort;
  logic                w_start_acc;

  logic                r_mem_we, r_mem_re;
  logic [AWIDTH-1:0]   r_mem_wraddr, r_mem_rdaddr;
  logic [DWIDTH-1:0]   r_mem_datain;
  logic                w_mem_we_d, w_mem_re_d;
  logic [DWIDTH-1:0]   w_mem_datain_d;

  logic                r_fail;
  logic [2:0]          r_fail_elem;
  logic [AWIDTH-1:0]   r_fail_addr;
  logic [DWIDTH-1:0]   r_fail_data;

  // Element / address bookkeeping
  assign w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
  assign w_last      = w_down ? (r_addr == '0) : (r_addr == LastAddr);
  assign w_addr_step = w_down ? (r_addr - AWIDTH'(1)) : (r_addr + AWIDTH'(1));
  // E3 and E4 run downward, so they start at the top address.
  assign w_addr_first_next = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? LastAddr : '0;

  // E2 and E4 expect ones, every other read element expects zeros.
  assign w_exp    = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? {DWIDTH{1'b1}} : {DWIDTH{1'b0}};
  assign w_miscmp = (r_state == StCmp) && (i_mem_dataout != w_exp);

`ifdef MBIST_DIAG_EN
  assign w_abort = 1'b0;
`else
  assign w_abort = w_miscmp;
`endif

  assign w_start_acc = i_start && ((r_state == StIdle) || (r_state == StDone));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_elem  <= 3'd0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_d;
      r_elem  <= w_elem_d;
      r_addr  <= w_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_elem_d  = r_elem;
    w_addr_d  = r_addr;
    case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d = StWr;
          w_elem_d  = 3'd0;
          w_addr_d  = '0;
        end
      end
      StWr: begin
        if (w_last) begin
          w_state_d = StRd;
          w_elem_d  = 3'd1;
          w_addr_d  = '0;
        end else begin
          w_addr_d  = w_addr_step;
        end
      end
      StRd: w_state_d = StCmp;
      StCmp: begin
        if (w_abort) begin
          w_state_d = StDone;
        end else if (w_last) begin
          if (r_elem == 3'd5) begin
            w_state_d = StDone;
          end else begin
            w_state_d = StRd;
            w_elem_d  = r_elem + 3'd1;
            w_addr_d  = w_addr_first_next;
          end
        end else begin
          w_state_d = StRd;
          w_addr_d  = w_addr_step;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic: memory controls are precomputed from the next state so the
  // registered port lines up with the state it belongs to.
  always_comb begin
    w_mem_we_d     = (w_state_d == StWr) || ((w_state_d == StCmp) && (w_elem_d != 3'd5));
    w_mem_re_d     = (w_state_d == StRd);
    w_mem_datain_d = ((w_elem_d == 3'd1) || (w_elem_d == 3'd3)) ? {DWIDTH{1'b1}}
                                                                 : {DWIDTH{1'b0}};
    o_busy         = (r_state == StWr) || (r_state == StRd) || (r_state == StCmp);
    o_done         = (r_state == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_wraddr <= '0;
      r_mem_rdaddr <= '0;
      r_mem_datain <= '0;
    end else begin
      r_mem_we     <= w_mem_we_d;
      r_mem_re     <= w_mem_re_d;
      r_mem_wraddr <= w_addr_d;
      r_mem_rdaddr <= w_addr_d;
      r_mem_datain <= w_mem_datain_d;
    end
  end

  // Read data only arrives in the CMP cycle itself, so suppressing that
  // cycle's write on a miscompare has to gate the registered enable.
  assign o_mem_we     = r_mem_we & ~w_abort;
  assign o_mem_re     = r_mem_re;
  assign o_mem_wraddr = r_mem_wraddr;
  assign o_mem_rdaddr = r_mem_rdaddr;
  assign o_mem_datain = r_mem_datain;

  // First-failure capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail      <= 1'b0;
      r_fail_elem <= 3'd0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_start_acc) begin
      r_fail      <= 1'b0;
      r_fail_elem <= 3'd0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_miscmp && !r_fail) begin
      r_fail      <= 1'b1;
      r_fail_elem <= r_elem;
      r_fail_addr <= r_addr;
      r_fail_data <= i_mem_dataout;
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_elem = r_fail_elem;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;

`ifdef MBIST_DIAG_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 16'd0;
    end else if (w_start_acc) begin
      r_err_cnt <= 16'd0;
    end else if (w_miscmp && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
`timescale 1ns/1ps
module tb_mbist_march_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned N     = 1 << AW;
  localparam int          Bound = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [2:0]    fail_elem;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_wraddr, mem_rdaddr;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout = '0;
`ifdef MBIST_DIAG_EN
  logic [15:0]   err_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_fail       (fail),
    .o_fail_elem  (fail_elem),
    .o_fail_addr  (fail_addr),
    .o_fail_data  (fail_data),
`ifdef MBIST_DIAG_EN
    .o_err_cnt    (err_cnt),
`endif
    .o_mem_we     (mem_we),
    .o_mem_wraddr (mem_wraddr),
    .o_mem_datain (mem_datain),
    .o_mem_re     (mem_re),
    .o_mem_rdaddr (mem_rdaddr),
    .i_mem_dataout(mem_dataout)
  );

  // Memory model: stuck-at faults act on the read path.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] sa0 [N];

  always @(posedge clk) begin
    if (mem_we) mem[mem_wraddr] <= mem_datain;
    if (mem_re) mem_dataout <= (mem[mem_rdaddr] | sa1[mem_rdaddr]) & ~sa0[mem_rdaddr];
  end

  // March C- as an operation table: read expectation / write value (-1 = none).
  int rd_pat [6] = '{-1, 0, 1, 0, 1, 0};
  int wr_pat [6] = '{0, 1, 0, 1, 0, -1};
  bit dn_ord [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  typedef struct {
    bit            fail;
    logic [2:0]    elem;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            busy;
    int            we;
    int            re;
    int            errs;
  } res_t;

  logic [DW-1:0] mmem [N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_run(output res_t r);
    bit            stop;
    bit            bad;
    int            a;
    logic [DW-1:0] rd;
    logic [DW-1:0] want;
    r.fail = 1'b0; r.elem = '0; r.addr = '0; r.data = '0;
    r.busy = 0; r.we = 0; r.re = 0; r.errs = 0;
    stop = 1'b0;
    for (int e = 0; e < 6 && !stop; e++) begin
      for (int i = 0; i < int'(N) && !stop; i++) begin
        a = dn_ord[e] ? int'(N) - 1 - i : i;
        bad = 1'b0;
        if (rd_pat[e] >= 0) begin
          r.busy += 2;
          r.re++;
          rd   = (mmem[a] | sa1[a]) & ~sa0[a];
          want = (rd_pat[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
          if (rd !== want) begin
            bad = 1'b1;
            r.errs++;
            if (!r.fail) begin
              r.fail = 1'b1;
              r.elem = 3'(e);
              r.addr = AW'(a);
              r.data = rd;
            end
          end
        end else begin
          r.busy += 1;
        end
`ifndef MBIST_DIAG_EN
        if (bad) stop = 1'b1;
`endif
        if (wr_pat[e] >= 0 && !stop) begin
          mmem[a] = (wr_pat[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
          r.we++;
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < int'(N); i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  task automatic add_fault(input int a, input int b, input bit pol);
    logic [DW-1:0] m;
    m = {{(DW-1){1'b0}}, 1'b1} << b;
    if (pol) sa1[a] = sa1[a] | m;
    else     sa0[a] = sa0[a] | m;
  endtask

  // Start a test, watch it to completion and compare against ex.
  task automatic run_one(input string tag, input res_t ex, input int glitch_at);
    int t, bc, wc, rc, mm_bad;
    bit seen;
    for (int i = 0; i < int'(N); i++) mem[i] = $urandom();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0; bc = 0; wc = 0; rc = 0; seen = 1'b0;
    while (!seen && t < Bound) begin
      @(negedge clk);
      t++;
      if (t == 1)
        check({tag, "/clear"}, {busy, done, fail, fail_elem, fail_addr, fail_data},
              {1'b1, 40'b0});
      start = (t == glitch_at);
      if (done) seen = 1'b1;
      else if (busy) bc++;
      if (mem_we) wc++;
      if (mem_re) rc++;
    end
    start = 1'b0;
    check({tag, "/done_seen"}, seen, 1'b1);
    check({tag, "/done_cycle"}, t, ex.busy + 1);
    check({tag, "/busy_cycles"}, bc, ex.busy);
    check({tag, "/busy_at_done"}, busy, 1'b0);
    check({tag, "/fail"}, fail, ex.fail);
    check({tag, "/fail_elem"}, fail_elem, ex.elem);
    check({tag, "/fail_addr"}, fail_addr, ex.addr);
    check({tag, "/fail_data"}, fail_data, ex.data);
    check({tag, "/we_count"}, wc, ex.we);
    check({tag, "/re_count"}, rc, ex.re);
`ifdef MBIST_DIAG_EN
    check({tag, "/err_cnt"}, err_cnt, ex.errs);
`endif
    mm_bad = 0;
    for (int i = 0; i < int'(N); i++) if (mem[i] !== mmem[i]) mm_bad++;
    check({tag, "/mem_image"}, mm_bad, 0);
    repeat (3) @(negedge clk);
    check({tag, "/done_hold"}, {busy, done, fail}, {1'b0, 1'b1, ex.fail});
  endtask

  function automatic logic [127:0] all_outs();
    return {busy, done, fail, fail_elem, fail_addr, fail_data,
`ifdef MBIST_DIAG_EN
            err_cnt,
`endif
            mem_we, mem_wraddr, mem_datain, mem_re, mem_rdaddr};
  endfunction

  typedef struct {
    int            fa;
    int            fb;
    bit            pol;
    bit            efail;
    int            eelem;
    int            eaddr;
    logic [DW-1:0] edata;
    int            ebusy;
    int            ewe;
    int            ere;
  } vec_t;

  vec_t tbl [5];

  initial begin
    res_t m;
    res_t ex;
    int   nf;

    // fault addr, bit, stuck value -> fail, elem, addr, data, busy cycles, writes, reads
    tbl[0] = '{-1, 0,  1'b0, 1'b0, 0, 0, 32'h0000_0000, 88, 40, 40};
    tbl[1] = '{5,  0,  1'b1, 1'b1, 1, 5, 32'h0000_0001, 20, 13, 6};
    tbl[2] = '{0,  31, 1'b0, 1'b1, 2, 0, 32'h7FFF_FFFF, 26, 16, 9};
    tbl[3] = '{7,  4,  1'b1, 1'b1, 1, 7, 32'h0000_0010, 24, 15, 8};
    tbl[4] = '{3,  0,  1'b0, 1'b1, 2, 3, 32'hFFFF_FFFE, 32, 19, 12};

    clear_faults();
    for (int i = 0; i < int'(N); i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      clear_faults();
      if (tbl[v].fa >= 0) add_fault(tbl[v].fa, tbl[v].fb, tbl[v].pol);
      model_run(m);
      ex = m;
`ifndef MBIST_DIAG_EN
      ex.fail = tbl[v].efail;
      ex.elem = 3'(tbl[v].eelem);
      ex.addr = AW'(tbl[v].eaddr);
      ex.data = tbl[v].edata;
      ex.busy = tbl[v].ebusy;
      ex.we   = tbl[v].ewe;
      ex.re   = tbl[v].ere;
`endif
      run_one($sformatf("tbl%0d", v), ex, -1);
    end

    // Reset in the middle of E3 aborts at once; a clean rerun follows.
    clear_faults();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (45) @(negedge clk);
    check("e3_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midtest_reset", all_outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    model_run(m);
    run_one("after_reset", m, -1);

    // Start pulses while busy must be ignored.
    model_run(m);
    run_one("glitch_e0", m, 3);
    run_one("glitch_e4", m, 60);

    // Randomised faults against the reference model.
    for (int r = 0; r < 20; r++) begin
      clear_faults();
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++)
        add_fault($urandom_range(0, N - 1), $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)));
      model_run(m);
      run_one($sformatf("rand%0d", r), m, (r % 3 == 0) ? 10 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
